// File: rtl/image_pixel_decode.sv
// image_pixel_decode: 3x3 Q4.12 colour transform back to 8-bit pixels using one shared multiplier
// Ports: clk, rst (sync, active-high); in_pix[48] {c0,c1,c2} signed 16-bit, in_valid/in_ready;
//        out_pix[24] {row2,row1,row0} unsigned 8-bit, out_sat (any channel clipped), out_valid/out_ready.
module image_pixel_decode #(
  parameter logic signed [15:0] K00 = 16'sd4096,
  parameter logic signed [15:0] K01 = 16'sd0,
  parameter logic signed [15:0] K02 = 16'sd0,
  parameter logic signed [15:0] K10 = 16'sd0,
  parameter logic signed [15:0] K11 = 16'sd4096,
  parameter logic signed [15:0] K12 = 16'sd0,
  parameter logic signed [15:0] K20 = 16'sd0,
  parameter logic signed [15:0] K21 = 16'sd0,
  parameter logic signed [15:0] K22 = 16'sd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] in_pix,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sat
);
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
  localparam logic [143:0] KV = {K22, K21, K20, K12, K11, K10, K02, K01, K00};
  state_t state, state_n;
  logic [47:0] pix;
  logic [1:0] row, col;
  logic [7:0] kbase, cbase;
  logic signed [15:0] coef, c;
  logic signed [31:0] prod;
  logic signed [33:0] acc, sum;
  logic signed [21:0] r;
  logic [7:0] ch;
  logic clip, row_end;
  assign kbase = 8'(row) * 8'd48 + 8'(col) * 8'd16;
  assign cbase = 8'd32 - 8'(col) * 8'd16;
  assign coef = KV[kbase +: 16];
  assign c = pix[cbase +: 16];
  assign prod = coef * c;
  assign sum = acc + 34'(prod);
  // round half up, then clamp to the 8-bit channel range
  assign r = 22'((sum + 34'sd2048) >>> 12);
  assign clip = (r < 0) || (r > 22'sd255);
  assign ch = (r < 0) ? 8'd0 : (r > 22'sd255) ? 8'd255 : r[7:0];
  assign row_end = col == 2'd2;
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (in_valid ? MAC : IDLE) :
              (state == MAC)  ? ((row == 2'd2 && row_end) ? HOLD : MAC) :
                                (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk)
    if (rst) begin
      pix <= '0;
      acc <= '0;
      row <= '0;
      col <= '0;
      out_pix <= '0;
      out_sat <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      pix <= in_pix;
      acc <= '0;
      row <= '0;
      col <= '0;
    end else if (state == MAC) begin
      acc <= row_end ? '0 : sum;
      col <= row_end ? 2'd0 : col + 2'd1;
      row <= row_end ? row + 2'd1 : row;
      if (row_end) begin
        out_pix[{row, 3'b000} +: 8] <= ch;
        out_sat <= ((row == 2'd0) ? 1'b0 : out_sat) | clip;
      end
    end
endmodule

// File: tb/tb_image_pixel_decode.sv
// tb_image_pixel_decode: scoreboard bench for two decoder instances (identity and general coefficients)
module tb_image_pixel_decode;
  typedef struct {logic [24:0] v; int t;} exp_t;
  localparam int KA[2][9] = '{'{4096, 0, 0, 0, 4096, 0, 0, 0, 4096},
                              '{2048, -1000, 300, 500, 4096, -2000, -4096, 1234, 8000}};
  logic clk = 0, rst = 1;
  logic [47:0] in_pix[2];
  logic in_valid[2], in_ready[2], out_valid[2], out_ready[2], out_sat[2];
  logic [23:0] out_pix[2];
  int cyc = 0, n = 0, nf = 0, busy = 0;
  exp_t sb[2][$];
  bit pv[2], phs[2], prst = 0;
  logic [24:0] ppix[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  image_pixel_decode u0 (.clk(clk), .rst(rst), .in_pix(in_pix[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_pix(out_pix[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sat(out_sat[0]));
  image_pixel_decode #(.K00(16'sd2048), .K01(-16'sd1000), .K02(16'sd300), .K10(16'sd500),
    .K11(16'sd4096), .K12(-16'sd2000), .K20(-16'sd4096), .K21(16'sd1234), .K22(16'sd8000)) u1 (
    .clk(clk), .rst(rst), .in_pix(in_pix[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_pix(out_pix[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sat(out_sat[1]));
  function automatic logic [24:0] model(int d, logic [47:0] p);
    logic [24:0] res = '0;
    for (int i = 0; i < 3; i++) begin
      longint a = 0;
      for (int j = 0; j < 3; j++)
        a += longint'(KA[d][i*3+j]) * longint'($signed(p[47-16*j -: 16]));
      a = (a + 2048) >>> 12;
      if (a < 0 || a > 255) res[24] = 1'b1;
      res[8*i +: 8] = (a < 0) ? 8'd0 : (a > 255) ? 8'd255 : 8'(a);
    end
    return res;
  endfunction
  task automatic chk(string nm, int d, logic [31:0] a, logic [31:0] e);
    n++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, a, e);
    end
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prst) chk("reset_state", d, {out_valid[d], out_sat[d], out_pix[d]}, 0);
      else begin
        if (pv[d] && !phs[d]) begin
          chk("hold_valid", d, out_valid[d], 1);
          chk("hold_stable", d, {out_sat[d], out_pix[d]}, ppix[d]);
        end
        if (phs[d]) chk("post_handshake", d, {out_valid[d], in_ready[d]}, {1'b0, !rst});
      end
      if (rst) begin
        chk("rst_in_ready", d, in_ready[d], 0);
        sb[d].delete();
      end else begin
        if (out_valid[d]) chk("busy_in_ready", d, in_ready[d], 0);
        if (out_valid[d] && !pv[d]) begin
          if (sb[d].size() == 0) chk("spurious_valid", d, out_valid[d], 0);
          else chk("latency", d, cyc + 1 - sb[d][0].t, 10);
        end
        if (in_valid[d] && in_ready[d]) sb[d].push_back('{model(d, in_pix[d]), cyc + 1});
        if (out_valid[d] && out_ready[d]) begin
          if (sb[d].size() == 0) chk("unexpected_output", d, {out_sat[d], out_pix[d]}, 0);
          else chk("pixel", d, {out_sat[d], out_pix[d]}, sb[d].pop_front().v);
        end
      end
      pv[d] = out_valid[d] === 1'b1;
      phs[d] = out_valid[d] && out_ready[d] && !rst;
      ppix[d] = {out_sat[d], out_pix[d]};
    end
    prst = rst;
  end
  task automatic idle(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input int d, input logic [47:0] p, input bit keep, output int t);
    in_pix[d] = p;
    in_valid[d] = 1;
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin
      @(negedge clk);
      if (in_ready[d]) t = cyc + 1;
      @(posedge clk);
      #1;
    end
    if (!keep) in_valid[d] = 0;
    if (t < 0) chk("accept_timeout", d, 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && (sb[0].size() + sb[1].size() > 0 || out_valid[0] || out_valid[1]); i++) idle(1);
    chk("drain", 0, sb[0].size() + sb[1].size(), 0);
  endtask
  task automatic rand_run(int d);
    int t;
    logic [47:0] p;
    repeat (30) begin
      p = $urandom_range(0, 1) ? {16'($urandom), 16'($urandom), 16'($urandom)}
        : {16'($urandom_range(0, 1200)), 16'($urandom_range(0, 1200)), 16'($urandom_range(0, 1200))};
      send(d, p, 0, t);
      idle($urandom_range(0, 3));
    end
    busy--;
  endtask
  initial begin
    int t, t2, re;
    for (int d = 0; d < 2; d++) begin
      in_pix[d] = '0;
      in_valid[d] = 0;
      out_ready[d] = 1;
    end
    idle(3);
    rst = 0;
    idle(1);
    send(0, 48'h0064_00C8_0032, 0, t);
    send(0, 48'h0190_FF00_0080, 0, t);
    drain();
    send(1, {16'sd3, 32'd0}, 0, t);
    send(1, {16'hFFFF, 32'd0}, 0, t);
    drain();
    out_ready[0] = 0;
    send(0, 48'h0123_0045_0678, 0, t);
    for (int i = 0; i < 20 && !out_valid[0]; i++) idle(1);
    chk("hold_reached", 0, out_valid[0], 1);
    idle(5);
    out_ready[0] = 1;
    drain();
    send(0, 48'h0010_0020_0030, 0, t);
    idle(3);
    rst = 1;
    idle(1);
    rst = 0;
    re = cyc;
    send(0, 48'h00AA_00BB_00CC, 0, t);
    chk("post_rst_accept", 0, t, re + 1);
    drain();
    send(0, 48'h0011_0022_0033, 1, t);
    send(0, 48'h0044_0055_0066, 0, t2);
    chk("throughput", 0, t2 - t, 11);
    drain();
    busy = 2;
    fork
      rand_run(0);
      rand_run(1);
      while (busy > 0) begin
        idle(1);
        out_ready[0] = 1'($urandom);
        out_ready[1] = 1'($urandom);
      end
    join
    out_ready[0] = 1;
    out_ready[1] = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n, nf);
    $finish;
  end
endmodule
